// File: rtl/stall_pkg.sv
// Shared encodings for the pipeline stall sequencer (stall_ctrl / stall_wdt).
package stall_pkg;

  // FSM state encodings
  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_STALL = 2'd1;
  localparam logic [1:0] ST_FIN   = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  // Stall cause encodings
  localparam logic [1:0] CAUSE_NONE = 2'd0;
  localparam logic [1:0] CAUSE_DC   = 2'd1;
  localparam logic [1:0] CAUSE_IC   = 2'd2;

  // Cause to latch on stall entry; D-cache wins when both request
  function automatic logic [1:0] req_cause(input logic dc, input logic ic);
    if (dc)      return CAUSE_DC;
    else if (ic) return CAUSE_IC;
    else         return CAUSE_NONE;
  endfunction

endpackage

// File: rtl/stall_wdt.sv
// Stall watchdog: counts consecutive STALL cycles and raises a sticky timeout flag.
// Only instantiated when STALL_WDT_EN is defined.
module stall_wdt #(
  parameter int unsigned WDT_LIMIT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_stall,
  input  logic clr,
  output logic timeout
);

  localparam int unsigned WDT_W = $clog2(WDT_LIMIT + 1);
  localparam logic [WDT_W-1:0] LIMIT = WDT_W'(WDT_LIMIT);

  logic [WDT_W-1:0] cnt_q;

  // Consecutive-stall counter, cleared outside STALL, saturating at the limit
  always_ff @(posedge clk) begin
    if (!rst_n)             cnt_q <= '0;
    else if (!in_stall)     cnt_q <= '0;
    else if (cnt_q != LIMIT) cnt_q <= cnt_q + WDT_W'(1);
  end

  // Sticky timeout flag, cleared only by reset or an accepted restart
  always_ff @(posedge clk) begin
    if (!rst_n)                          timeout <= 1'b0;
    else if (clr)                        timeout <= 1'b0;
    else if (in_stall && cnt_q == LIMIT) timeout <= 1'b1;
  end

endmodule

// File: rtl/stall_ctrl.sv
// Central pipeline stall sequencer: merges D-cache, I-cache and monitor-halt
// requests into one stall and derives the EX rollback timing strobes.
// Optional watchdog enabled by defining STALL_WDT_EN.
module stall_ctrl
  import stall_pkg::*;
#(
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned WDT_LIMIT = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dc_stall_req,
  input  logic             ic_stall_req,
  input  logic             cpu_run,
  input  logic             cpu_start,
  output logic             stall,
  output logic             stall_1shot,
  output logic             stall_dly,
  output logic             stall_dly2,
  output logic             dc_stall_fin,
  output logic             rst_pipe,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             stall_timeout
);

  logic [1:0] state_q, state_d;
  logic [1:0] cause_q, cause_d;
  logic       req_any;
  logic       start_ok;
  logic       dc_fin_d;
  logic       rst_pipe_d;

  // Freeze applies in the same cycle as the request
  assign req_any     = dc_stall_req | ic_stall_req;
  assign stall       = req_any | (state_q == ST_HALT);
  assign stall_1shot = stall & ~stall_dly;
  assign start_ok    = cpu_start & cpu_run & (state_q == ST_HALT);

  // Next-state, cause tracking and registered-strobe decode
  always_comb begin
    state_d    = state_q;
    cause_d    = cause_q;
    dc_fin_d   = 1'b0;
    rst_pipe_d = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (req_any) begin
          state_d = ST_STALL;
          cause_d = req_cause(dc_stall_req, ic_stall_req);
        end else if (!cpu_run) begin
          state_d = ST_HALT;
        end
      end
      ST_STALL: begin
        if (req_any) begin
          if (dc_stall_req) cause_d = CAUSE_DC;
        end else begin
          state_d  = ST_FIN;
          dc_fin_d = (cause_q == CAUSE_DC);
        end
      end
      ST_FIN: begin
        cause_d = CAUSE_NONE;
        if (req_any) begin
          state_d = ST_STALL;
          cause_d = req_cause(dc_stall_req, ic_stall_req);
        end else if (!cpu_run) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_HALT: begin
        if (start_ok) begin
          rst_pipe_d = 1'b1;
          if (req_any) begin
            state_d = ST_STALL;
            cause_d = req_cause(dc_stall_req, ic_stall_req);
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      default: begin
        state_d = ST_RUN;
        cause_d = CAUSE_NONE;
      end
    endcase
  end

  // State, delayed stalls, pulses and the stall performance counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      cause_q      <= CAUSE_NONE;
      stall_dly    <= 1'b0;
      stall_dly2   <= 1'b0;
      dc_stall_fin <= 1'b0;
      rst_pipe     <= 1'b0;
      stall_cnt    <= '0;
    end else begin
      state_q      <= state_d;
      cause_q      <= cause_d;
      stall_dly    <= stall;
      stall_dly2   <= stall_dly;
      dc_stall_fin <= dc_fin_d;
      rst_pipe     <= rst_pipe_d;
      stall_cnt    <= stall_cnt + CNT_W'(stall);
    end
  end

`ifdef STALL_WDT_EN
  // Watchdog on long stalls; an accepted restart clears the flag
  stall_wdt #(
    .WDT_LIMIT (WDT_LIMIT)
  ) u_wdt (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_stall (state_q == ST_STALL),
    .clr      (start_ok),
    .timeout  (stall_timeout)
  );
`else
  // No watchdog: flag tied low, limit parameter has no effect
  logic unused_wdt_cfg;
  assign unused_wdt_cfg = ^WDT_LIMIT;
  assign stall_timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_stall_ctrl.sv
// Directed-vector bench for stall_ctrl. Each vec() call is one clock cycle:
// inputs are applied 1 time unit after posedge and outputs sampled 2 units later.
module tb_stall_ctrl;

`ifdef STALL_WDT_EN
  localparam bit WDT_ON = 1'b1;
`else
  localparam bit WDT_ON = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        dc_stall_req;
  logic        ic_stall_req;
  logic        cpu_run;
  logic        cpu_start;
  logic        stall;
  logic        stall_1shot;
  logic        stall_dly;
  logic        stall_dly2;
  logic        dc_stall_fin;
  logic        rst_pipe;
  logic [31:0] stall_cnt;
  logic        stall_timeout;

  int n_checks = 0;
  int n_errors = 0;
  int cyc_no   = 0;

  stall_ctrl #(
    .CNT_W     (32),
    .WDT_LIMIT (8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .dc_stall_req  (dc_stall_req),
    .ic_stall_req  (ic_stall_req),
    .cpu_run       (cpu_run),
    .cpu_start     (cpu_start),
    .stall         (stall),
    .stall_1shot   (stall_1shot),
    .stall_dly     (stall_dly),
    .stall_dly2    (stall_dly2),
    .dc_stall_fin  (dc_stall_fin),
    .rst_pipe      (rst_pipe),
    .stall_cnt     (stall_cnt),
    .stall_timeout (stall_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", tag, cyc_no, got, exp);
    end
  endtask

  // One cycle: drive inputs, then compare every output against the row
  task automatic vec(input logic dc, input logic ic, input logic run, input logic start,
                     input logic rn,
                     input logic e_stall, input logic e_1s, input logic e_dly,
                     input logic e_dly2, input logic e_fin, input logic e_rp,
                     input int e_cnt, input logic e_to);
    @(posedge clk);
    #1;
    dc_stall_req = dc;
    ic_stall_req = ic;
    cpu_run      = run;
    cpu_start    = start;
    rst_n        = rn;
    #2;
    check_eq("stall",         32'(stall),         32'(e_stall));
    check_eq("stall_1shot",   32'(stall_1shot),   32'(e_1s));
    check_eq("stall_dly",     32'(stall_dly),     32'(e_dly));
    check_eq("stall_dly2",    32'(stall_dly2),    32'(e_dly2));
    check_eq("dc_stall_fin",  32'(dc_stall_fin),  32'(e_fin));
    check_eq("rst_pipe",      32'(rst_pipe),      32'(e_rp));
    check_eq("stall_cnt",     stall_cnt,          32'(e_cnt));
    check_eq("stall_timeout", 32'(stall_timeout), 32'(e_to));
    cyc_no++;
  endtask

  initial begin
    rst_n        = 1'b0;
    dc_stall_req = 1'b0;
    ic_stall_req = 1'b0;
    cpu_run      = 1'b1;
    cpu_start    = 1'b0;
    repeat (2) @(posedge clk);

    //   dc ic run st rn   stl 1s dly d2 fin rp  cnt to
    // reset state
    vec(0, 0, 1, 0, 0,   0, 0, 0, 0, 0, 0,   0, 0);
    vec(0, 0, 1, 0, 1,   0, 0, 0, 0, 0, 0,   0, 0);
    // D-cache stall, 5 cycles
    vec(1, 0, 1, 0, 1,   1, 1, 0, 0, 0, 0,   0, 0);
    vec(1, 0, 1, 0, 1,   1, 0, 1, 0, 0, 0,   1, 0);
    vec(1, 0, 1, 0, 1,   1, 0, 1, 1, 0, 0,   2, 0);
    vec(1, 0, 1, 0, 1,   1, 0, 1, 1, 0, 0,   3, 0);
    vec(1, 0, 1, 0, 1,   1, 0, 1, 1, 0, 0,   4, 0);
    vec(0, 0, 1, 0, 1,   0, 0, 1, 1, 0, 0,   5, 0);
    vec(0, 0, 1, 0, 1,   0, 0, 0, 1, 1, 0,   5, 0);
    vec(0, 0, 1, 0, 1,   0, 0, 0, 0, 0, 0,   5, 0);
    // I-cache stall, 3 cycles: no fin pulse
    vec(0, 1, 1, 0, 1,   1, 1, 0, 0, 0, 0,   5, 0);
    vec(0, 1, 1, 0, 1,   1, 0, 1, 0, 0, 0,   6, 0);
    vec(0, 1, 1, 0, 1,   1, 0, 1, 1, 0, 0,   7, 0);
    vec(0, 0, 1, 0, 1,   0, 0, 1, 1, 0, 0,   8, 0);
    vec(0, 0, 1, 0, 1,   0, 0, 0, 1, 0, 0,   8, 0);
    vec(0, 0, 1, 0, 1,   0, 0, 0, 0, 0, 0,   8, 0);
    // IC first, DC joins: cause upgrades to DC
    vec(0, 1, 1, 0, 1,   1, 1, 0, 0, 0, 0,   8, 0);
    vec(1, 1, 1, 0, 1,   1, 0, 1, 0, 0, 0,   9, 0);
    vec(1, 1, 1, 0, 1,   1, 0, 1, 1, 0, 0,  10, 0);
    vec(1, 1, 1, 0, 1,   1, 0, 1, 1, 0, 0,  11, 0);
    vec(1, 1, 1, 0, 1,   1, 0, 1, 1, 0, 0,  12, 0);
    vec(0, 0, 1, 0, 1,   0, 0, 1, 1, 0, 0,  13, 0);
    vec(0, 0, 1, 0, 1,   0, 0, 0, 1, 1, 0,  13, 0);
    vec(0, 0, 1, 0, 1,   0, 0, 0, 0, 0, 0,  13, 0);
    // 1-cycle request, then a new request during FIN
    vec(1, 0, 1, 0, 1,   1, 1, 0, 0, 0, 0,  13, 0);
    vec(0, 0, 1, 0, 1,   0, 0, 1, 0, 0, 0,  14, 0);
    vec(1, 0, 1, 0, 1,   1, 1, 0, 1, 1, 0,  14, 0);
    vec(1, 0, 1, 0, 1,   1, 0, 1, 0, 0, 0,  15, 0);
    vec(0, 0, 1, 0, 1,   0, 0, 1, 1, 0, 0,  16, 0);
    vec(0, 0, 1, 0, 1,   0, 0, 0, 1, 1, 0,  16, 0);
    vec(0, 0, 1, 0, 1,   0, 0, 0, 0, 0, 0,  16, 0);
    // request with cpu_run falling: STALL first, HALT from FIN
    vec(1, 0, 0, 0, 1,   1, 1, 0, 0, 0, 0,  16, 0);
    vec(0, 0, 0, 0, 1,   0, 0, 1, 0, 0, 0,  17, 0);
    vec(0, 0, 0, 0, 1,   0, 0, 0, 1, 1, 0,  17, 0);
    // HALT; cpu_start with cpu_run low is ignored
    vec(0, 0, 0, 1, 1,   1, 1, 0, 0, 0, 0,  17, 0);
    vec(0, 0, 0, 0, 1,   1, 0, 1, 0, 0, 0,  18, 0);
    // accepted restart: one rst_pipe pulse, back to RUN
    vec(0, 0, 1, 1, 1,   1, 0, 1, 1, 0, 0,  19, 0);
    vec(0, 0, 1, 0, 1,   0, 0, 1, 1, 0, 1,  20, 0);
    vec(0, 0, 1, 0, 1,   0, 0, 0, 1, 0, 0,  20, 0);
    vec(0, 0, 1, 0, 1,   0, 0, 0, 0, 0, 0,  20, 0);
    // cpu_start outside HALT: no rst_pipe
    vec(0, 0, 1, 1, 1,   0, 0, 0, 0, 0, 0,  20, 0);
    vec(0, 0, 1, 0, 1,   0, 0, 0, 0, 0, 0,  20, 0);
    // halt, then restart with a pending DC request -> STALL with rst_pipe
    vec(0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0,  20, 0);
    vec(1, 0, 0, 0, 1,   1, 1, 0, 0, 0, 0,  20, 0);
    vec(1, 0, 1, 1, 1,   1, 0, 1, 0, 0, 0,  21, 0);
    vec(0, 0, 1, 0, 1,   0, 0, 1, 1, 0, 1,  22, 0);
    vec(0, 0, 1, 0, 1,   0, 0, 0, 1, 1, 0,  22, 0);
    vec(0, 0, 1, 0, 1,   0, 0, 0, 0, 0, 0,  22, 0);
    // reset mid DC stall: everything clears, no fin pulse
    vec(1, 0, 1, 0, 1,   1, 1, 0, 0, 0, 0,  22, 0);
    vec(1, 0, 1, 0, 1,   1, 0, 1, 0, 0, 0,  23, 0);
    vec(0, 0, 1, 0, 0,   0, 0, 1, 1, 0, 0,  24, 0);
    vec(0, 0, 1, 0, 1,   0, 0, 0, 0, 0, 0,   0, 0);
    vec(0, 0, 1, 0, 1,   0, 0, 0, 0, 0, 0,   0, 0);

    // long DC stall: with the watchdog (limit 8) the flag rises and sticks
    for (int k = 0; k < 20; k++)
      vec(1, 0, 1, 0, 1,   1, (k == 0), (k > 0), (k > 1), 0, 0,   k, WDT_ON && (k >= 10));
    vec(0, 0, 1, 0, 1,   0, 0, 1, 1, 0, 0,  20, WDT_ON);
    vec(0, 0, 1, 0, 1,   0, 0, 0, 1, 1, 0,  20, WDT_ON);
    vec(0, 0, 1, 0, 1,   0, 0, 0, 0, 0, 0,  20, WDT_ON);
    vec(0, 0, 1, 0, 0,   0, 0, 0, 0, 0, 0,  20, WDT_ON);
    vec(0, 0, 1, 0, 1,   0, 0, 0, 0, 0, 0,   0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Safety net against a stuck simulation
  initial begin
    #200000;
    $display("FAIL sim_timeout @cyc %0d: got no finish, expected finish", cyc_no);
    $fatal(1, "simulation time limit reached");
  end

endmodule
